host_dma_burst_engine: RTL and testbench

//  Parametrised AXI4 master DMA between host memory and the accelerator. Read path streams host data to the

---
 rtl/host_dma_burst_engine.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_host_dma_burst_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_dma_burst_engine.sv
// host_dma_burst_engine: AXI4 master DMA between host memory and the accelerator.
//   Read path: a start pulse (load_weights / model_start) launches a job of
//   xfer_beats beats. Up to MAX_OUTSTANDING bursts of up to BURST_LEN beats are
//   kept in flight. Returned data is steered to ddr_din_* (weights) or blob_din_*
//   (model).
//   Write path: blob_dout beats are buffered in a FIFO. They are emitted as write
//   bursts of BURST_LEN beats, or flushed early up to and including an eop beat.
// Ports: clk/rst (async active-high); start pulses, xfer_beats, host base addresses;
//   busy/rd_done/wr_done status; full AXI4 master AR/R/AW/W/B channels;
//   blob_dout_* (in), blob_din_* and ddr_din_* (out), ddr_write_length.
// Latency: R beats reach blob_din/ddr_din combinationally. rd_done and wr_done
//   are registered one-cycle pulses.
// Backpressure: rready follows the selected sink's rdy. blob_dout_rdy drops when
//   the write FIFO is full.
module host_dma_burst_engine #(
  parameter int C_M_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int BURST_LEN          = 16,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int WFIFO_DEPTH        = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_weights,
  input  logic                            model_start,
  input  logic [31:0]                     xfer_beats,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   host_weights_addr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   host_src_addr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   host_dst_addr,
  output logic                            busy,
  output logic                            rd_done,
  output logic                            wr_done,
  // read address
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic [3:0]                      m_axi_arqos,
  output logic                            m_axi_aruser,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  // read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  // write address
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awlock,
  output logic [3:0]                      m_axi_awcache,
  output logic [2:0]                      m_axi_awprot,
  output logic [3:0]                      m_axi_awqos,
  output logic                            m_axi_awuser,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  // write data / response
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  // accelerator output -> host
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   blob_dout,
  input  logic                            blob_dout_en,
  input  logic                            blob_dout_eop,
  output logic                            blob_dout_rdy,
  // host -> accelerator input
  output logic [C_M_AXI_DATA_WIDTH-1:0]   blob_din,
  output logic                            blob_din_en,
  output logic                            blob_din_eop,
  input  logic                            blob_din_rdy,
  // host -> DDR weight loader
  output logic [C_M_AXI_DATA_WIDTH-1:0]   ddr_din,
  output logic                            ddr_din_en,
  output logic                            ddr_din_eop,
  input  logic                            ddr_din_rdy,
  output logic [26:0]                     ddr_write_length
);

  localparam int AWD   = C_M_AXI_ADDR_WIDTH;
  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int PW    = $clog2(WFIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int LW    = $clog2(BURST_LEN) + 1;
  localparam int OW    = 5;

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_t;

  // constant AXI attributes
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_aruser  = 1'b1;
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'($clog2(BYTES));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awuser  = 1'b1;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;

  // ---------------- read path ----------------
  rd_state_t        state, state_n;
  logic             lw_q, ms_q, mode;
  logic [31:0]      rem_ar, rem_r, rd_len;
  logic [OW-1:0]    outstanding;
  logic             lw_rise, ms_rise, start_ok, ar_hs, r_hs, r_last_hs;

  assign lw_rise   = load_weights & ~lw_q;
  assign ms_rise   = model_start & ~ms_q;
  // load_weights wins when both rise together; any start while busy is dropped
  assign start_ok  = (state == RD_IDLE) & (lw_rise | ms_rise);
  assign rd_len    = (rem_ar > 32'(BURST_LEN)) ? 32'(BURST_LEN) : rem_ar;
  assign m_axi_arlen = 8'(rd_len - 32'd1);
  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign r_last_hs = r_hs & m_axi_rlast;
  assign busy      = (state != RD_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    m_axi_arvalid = 1'b0;
    case (state)
      RD_IDLE:  if (start_ok && xfer_beats != 32'd0) state_n = RD_ISSUE;
      RD_ISSUE: begin
        // depends only on registered state, so it stays stable until arready
        m_axi_arvalid = (outstanding < OW'(MAX_OUTSTANDING)) && (rem_ar != 32'd0);
        if (ar_hs && rem_ar == rd_len) state_n = RD_DRAIN;
      end
      RD_DRAIN: if (rem_r == 32'd0) state_n = RD_IDLE;
      default:  state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_q <= 1'b0; ms_q <= 1'b0; mode <= 1'b0;
      m_axi_araddr <= '0; rem_ar <= '0; rem_r <= '0;
      outstanding <= '0; ddr_write_length <= '0; rd_done <= 1'b0;
    end else begin
      lw_q    <= load_weights;
      ms_q    <= model_start;
      rd_done <= ((state == RD_DRAIN) && (rem_r == 32'd0)) ||
                 (start_ok && xfer_beats == 32'd0);
      if (start_ok) begin
        mode         <= lw_rise;
        m_axi_araddr <= lw_rise ? host_weights_addr : host_src_addr;
        rem_ar       <= xfer_beats;
        rem_r        <= xfer_beats;
        if (lw_rise) ddr_write_length <= xfer_beats[26:0];
      end else begin
        if (ar_hs) begin
          m_axi_araddr <= m_axi_araddr + AWD'(rd_len * 32'(BYTES));
          rem_ar       <= rem_ar - rd_len;
        end
        if (r_hs && rem_r != 32'd0) rem_r <= rem_r - 32'd1;
      end
      case ({ar_hs, r_last_hs && outstanding != '0})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign m_axi_rready = mode ? ddr_din_rdy : blob_din_rdy;
  assign blob_din     = m_axi_rdata;
  assign ddr_din      = m_axi_rdata;
  assign blob_din_en  = ~mode & m_axi_rvalid;
  assign ddr_din_en   = mode & m_axi_rvalid;
  assign blob_din_eop = ~mode & r_hs & (rem_r == 32'd1);
  assign ddr_din_eop  = mode & r_hs & (rem_r == 32'd1);

  // ---------------- write path ----------------
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_dat [WFIFO_DEPTH];
  logic [WFIFO_DEPTH-1:0]        fifo_eop;
  logic [PW-1:0]                 wr_ptr, rd_ptr, idx;
  logic [CW-1:0]                 count;
  logic                          push, pop, w_hs, aw_hs, b_hs;
  logic                          wb_busy, aw_pend, w_act, cur_eop;
  logic [LW-1:0]                 w_len, w_cnt, fl_len, wb_len;
  logic                          fl_found, trigger;

  assign blob_dout_rdy = (count != CW'(WFIFO_DEPTH));
  assign push  = blob_dout_en & blob_dout_rdy;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign pop   = w_hs;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  // a burst only retires after both AW and all W beats have gone out
  assign b_hs  = m_axi_bvalid & m_axi_bready & wb_busy & ~aw_pend & ~w_act;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= blob_dout;
      fifo_eop[wr_ptr] <= blob_dout_eop;
    end
  end

  // Bursts are only scheduled while no burst is in progress, so every FIFO
  // entry is unassigned and the eop search can start at the head.
  always_comb begin
    fl_found = 1'b0;
    fl_len   = '0;
    idx      = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      idx = rd_ptr + PW'(i);
      if (!fl_found && (CW'(i) < count) && fifo_eop[idx]) begin
        fl_found = 1'b1;
        fl_len   = LW'(i + 1);
      end
    end
  end

  assign trigger = ~wb_busy & (fl_found | (count >= CW'(BURST_LEN)));
  assign wb_len  = fl_found ? fl_len : LW'(BURST_LEN);

  assign m_axi_awvalid = aw_pend;
  assign m_axi_wvalid  = w_act & (count != '0);
  assign m_axi_wlast   = w_act & (w_cnt == w_len - LW'(1));
  assign m_axi_wdata   = fifo_dat[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
      wb_busy <= 1'b0; aw_pend <= 1'b0; w_act <= 1'b0; cur_eop <= 1'b0;
      w_len <= '0; w_cnt <= '0; m_axi_awlen <= '0; m_axi_awaddr <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (trigger) begin
        wb_busy     <= 1'b1;
        aw_pend     <= 1'b1;
        w_act       <= 1'b1;
        w_len       <= wb_len;
        w_cnt       <= '0;
        cur_eop     <= fl_found;
        m_axi_awlen <= 8'(wb_len - LW'(1));
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs) begin
        w_cnt <= w_cnt + LW'(1);
        if (m_axi_wlast) w_act <= 1'b0;
      end
      if (b_hs) begin
        wb_busy <= 1'b0;
        wr_done <= cur_eop;
      end

      if (start_ok && !lw_rise)
        m_axi_awaddr <= host_dst_addr;
      else if (aw_hs)
        m_axi_awaddr <= m_axi_awaddr + AWD'(int'(w_len) * BYTES);
    end
  end

endmodule

// File: tb/tb_host_dma_burst_engine.sv
module tb_host_dma_burst_engine;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct { logic [511:0] dat; logic last; } beat_t;

  logic clk, rst, load_weights, model_start;
  logic [31:0] xfer_beats, host_weights_addr, host_src_addr, host_dst_addr;
  logic busy, rd_done, wr_done;
  logic [3:0] arid, awid, arcache, awcache, arqos, awqos;
  logic [31:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst;
  logic arlock, awlock, aruser, awuser, arvalid, arready, awvalid, awready;
  logic [511:0] rdata, wdata, blob_dout, blob_din, ddr_din;
  logic [63:0] wstrb;
  logic rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;
  logic blob_dout_en, blob_dout_eop, blob_dout_rdy;
  logic blob_din_en, blob_din_eop, blob_din_rdy;
  logic ddr_din_en, ddr_din_eop, ddr_din_rdy;
  logic [26:0] ddr_write_length;

  host_dma_burst_engine dut (
    .clk(clk), .rst(rst), .load_weights(load_weights), .model_start(model_start),
    .xfer_beats(xfer_beats), .host_weights_addr(host_weights_addr),
    .host_src_addr(host_src_addr), .host_dst_addr(host_dst_addr),
    .busy(busy), .rd_done(rd_done), .wr_done(wr_done),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_aruser(aruser),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awuser(awuser),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .blob_dout(blob_dout), .blob_dout_en(blob_dout_en), .blob_dout_eop(blob_dout_eop),
    .blob_dout_rdy(blob_dout_rdy),
    .blob_din(blob_din), .blob_din_en(blob_din_en), .blob_din_eop(blob_din_eop),
    .blob_din_rdy(blob_din_rdy),
    .ddr_din(ddr_din), .ddr_din_en(ddr_din_en), .ddr_din_eop(ddr_din_eop),
    .ddr_din_rdy(ddr_din_rdy), .ddr_write_length(ddr_write_length)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h required=%0h", tag, got, exp);
  endtask

  function automatic logic [511:0] mem_word(input logic [31:0] a);
    logic [511:0] w;
    for (int l = 0; l < 16; l++) w[32*l +: 32] = a + 32'(l);
    return w;
  endfunction

  // scoreboard queues and slave model state
  ax_t   exp_ar_q[$], exp_aw_q[$], rb_q[$];
  beat_t exp_rd_q[$], exp_w_q[$], push_q[$];
  int    rbeat = 0, r_stall = 0, b_pend = 0, b_cnt = 0;
  int    ar_cnt = 0, rd_beats = 0, rd_done_cnt = 0, wr_done_cnt = 0, exp_b_at_done = 0;
  bit    exp_mode = 0, ar_rand = 0, ar_block = 0, din_rand = 0, w_rand = 0, w_block = 0;

  task automatic exp_read(input bit w, input logic [31:0] base, input int n);
    int rem; logic [31:0] a; ax_t x; beat_t b;
    exp_mode = w;
    for (int i = 0; i < n; i++) begin
      b.dat = mem_word(base + 32'(i) * 32'd64); b.last = (i == n - 1);
      exp_rd_q.push_back(b);
    end
    rem = n; a = base;
    while (rem > 0) begin
      x.addr = a; x.len = 8'(((rem > 16) ? 16 : rem) - 1);
      exp_ar_q.push_back(x);
      a = a + 32'((int'(x.len) + 1) * 64); rem = rem - (int'(x.len) + 1);
    end
  endtask

  // AXI slave + sink/source driver and monitor: drive at negedge, observe 1ns later
  initial begin : slave
    ax_t x; beat_t b; logic [511:0] od; logic oe, oeo;
    forever begin
      @(negedge clk);
      arready = ar_block ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (r_stall > 0) begin r_stall--; rvalid = 1'b0; end
      else rvalid = (rb_q.size() > 0);
      if (rb_q.size() > 0) begin
        rdata = mem_word(rb_q[0].addr + 32'(rbeat) * 32'd64);
        rlast = (rbeat == int'(rb_q[0].len));
      end else begin rdata = '0; rlast = 1'b0; end
      blob_din_rdy = din_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr_din_rdy  = 1'b1;
      awready = 1'b1;
      wready  = w_block ? 1'b0 : (w_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      bvalid  = (b_pend > 0);
      blob_dout_en = (push_q.size() > 0);
      if (push_q.size() > 0) begin blob_dout = push_q[0].dat; blob_dout_eop = push_q[0].last; end
      else begin blob_dout = '0; blob_dout_eop = 1'b0; end
      #1;
      if (!rst) begin
        if (arvalid && arready) begin
          ar_cnt++;
          x.addr = araddr; x.len = arlen; rb_q.push_back(x);
          if (exp_ar_q.size() == 0) chk("ar_unexpected", 0, 1);
          else begin
            x = exp_ar_q.pop_front();
            chk("araddr", araddr, x.addr); chk("arlen", arlen, x.len);
          end
        end
        if (rvalid && rready) begin
          od = exp_mode ? ddr_din : blob_din;
          oe = exp_mode ? ddr_din_en : blob_din_en;
          oeo = exp_mode ? ddr_din_eop : blob_din_eop;
          rd_beats++;
          if (exp_rd_q.size() == 0) chk("rd_unexpected", 0, 1);
          else begin
            b = exp_rd_q.pop_front();
            chk("rd_dat", od, b.dat); chk("rd_eop", oeo, b.last); chk("rd_en", oe, 1);
          end
          if (rlast) begin void'(rb_q.pop_front()); rbeat = 0; end
          else rbeat++;
        end
        if (awvalid && awready) begin
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 0, 1);
          else begin
            x = exp_aw_q.pop_front();
            chk("awaddr", awaddr, x.addr); chk("awlen", awlen, x.len);
          end
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) chk("w_unexpected", 0, 1);
          else begin
            b = exp_w_q.pop_front();
            chk("wdata", wdata, b.dat); chk("wlast", wlast, b.last);
          end
          if (wlast) b_pend++;
        end
        if (bvalid && bready) begin b_pend--; b_cnt++; end
        if (blob_dout_en && blob_dout_rdy) void'(push_q.pop_front());
        if (rd_done) rd_done_cnt++;
        if (wr_done) begin wr_done_cnt++; chk("wr_done_after_b", b_cnt, exp_b_at_done); end
      end
    end
  end

  task automatic start_job(input bit w, input logic [31:0] n);
    @(negedge clk);
    xfer_beats = n;
    if (w) load_weights = 1'b1; else model_start = 1'b1;
    @(negedge clk);
    load_weights = 1'b0; model_start = 1'b0;
  endtask

  task automatic wait_rd_done(input string tag, input int budget);
    int c = 0; int s = rd_done_cnt;
    while (rd_done_cnt == s && c < budget) begin @(posedge clk); c++; end
    @(negedge clk); #2;
    chk(tag, (rd_done_cnt != s), 1);
  endtask

  initial begin : main
    int ar0, rd0, wd0, c; beat_t b; ax_t x;
    rst = 1'b1; load_weights = 1'b0; model_start = 1'b0; xfer_beats = '0;
    host_weights_addr = 32'h1000_0000; host_src_addr = 32'h2000_0000; host_dst_addr = 32'h3000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0); chk("rst_rd_done", rd_done, 0); chk("rst_wr_done", wr_done, 0);
    chk("rst_araddr", araddr, 0); chk("rst_awaddr", awaddr, 0); chk("rst_dwl", ddr_write_length, 0);
    @(negedge clk); rst = 1'b0;

    // 1: weights job of 40 beats -> bursts 16,16,8
    exp_read(1, host_weights_addr, 40);
    rd0 = rd_done_cnt; start_job(1, 40);
    wait_rd_done("t1_rd_done", 500);
    repeat (3) @(posedge clk); #1;
    chk("t1_dwl", ddr_write_length, 40); chk("t1_rd_done_once", rd_done_cnt - rd0, 1);
    chk("t1_ar_left", exp_ar_q.size(), 0); chk("t1_rd_left", exp_rd_q.size(), 0);

    // 2: model 128 with R stalled -> outstanding cap of 4
    exp_read(0, host_src_addr, 128);
    ar0 = ar_cnt; r_stall = 22; start_job(0, 128);
    repeat (15) @(posedge clk); @(negedge clk); #2;
    chk("t2_ar_cap", ar_cnt - ar0, 4); chk("t2_arvalid_low", arvalid, 0); chk("t2_busy", busy, 1);
    wait_rd_done("t2_rd_done", 1000);
    chk("t2_ar_total", ar_cnt - ar0, 8); chk("t2_rd_left", exp_rd_q.size(), 0);

    // 3: random blob_din_rdy and arready
    exp_read(0, host_src_addr + 32'h0001_0000, 128);
    host_src_addr = host_src_addr + 32'h0001_0000;
    din_rand = 1; ar_rand = 1; rd0 = rd_beats;
    start_job(0, 128);
    wait_rd_done("t3_rd_done", 3000);
    din_rand = 0; ar_rand = 0;
    chk("t3_beats", rd_beats - rd0, 128); chk("t3_rd_left", exp_rd_q.size(), 0);
    chk("t3_ar_left", exp_ar_q.size(), 0);

    // 4: 37 write beats with eop on the last -> 16,16,5
    b_cnt = 0; exp_b_at_done = 3; w_rand = 1; wd0 = wr_done_cnt;
    for (int k = 0; k < 3; k++) begin
      x.addr = host_dst_addr + 32'(k * 1024); x.len = (k == 2) ? 8'd4 : 8'd15;
      exp_aw_q.push_back(x);
    end
    for (int i = 1; i <= 37; i++) begin
      b.dat = {16{32'hB000_0000 + 32'(i)}}; b.last = (i == 37);
      push_q.push_back(b);
      b.last = (i == 16) || (i == 32) || (i == 37);
      exp_w_q.push_back(b);
    end
    c = 0;
    while (wr_done_cnt == wd0 && c < 2000) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk); #1;
    w_rand = 0;
    chk("t4_wr_done_once", wr_done_cnt - wd0, 1); chk("t4_b_cnt", b_cnt, 3);
    chk("t4_aw_left", exp_aw_q.size(), 0); chk("t4_w_left", exp_w_q.size(), 0);

    // 5: zero-length job, then a start while busy is ignored
    rd0 = rd_done_cnt; ar0 = ar_cnt;
    @(negedge clk); xfer_beats = 0; model_start = 1'b1;
    @(posedge clk); #1;
    chk("t5_zero_rd_done", rd_done, 1); chk("t5_zero_busy", busy, 0);
    @(negedge clk); model_start = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("t5_zero_no_ar", ar_cnt - ar0, 0);
    exp_read(0, host_src_addr, 64);
    start_job(0, 64);
    @(posedge clk); #1; chk("t5_busy", busy, 1);
    start_job(0, 32);
    wait_rd_done("t5_rd_done", 1000);
    repeat (5) @(posedge clk); #1;
    chk("t5_ar_total", ar_cnt - ar0, 4); chk("t5_rd_done_cnt", rd_done_cnt - rd0, 2);
    chk("t5_rd_left", exp_rd_q.size(), 0);

    // 6: reset with arvalid and wvalid both high
    ar_block = 1; w_block = 1;
    exp_read(0, host_src_addr, 128);
    x.addr = host_dst_addr; x.len = 8'd15; exp_aw_q.push_back(x);
    for (int i = 0; i < 20; i++) begin
      b.dat = {16{32'hC000_0000 + 32'(i)}}; b.last = 1'b0; push_q.push_back(b);
    end
    start_job(0, 128);
    repeat (30) @(posedge clk);
    @(negedge clk); #3;
    chk("t6_pre_arvalid", arvalid, 1); chk("t6_pre_wvalid", wvalid, 1);
    rst = 1'b1; #1;
    chk("t6_arvalid", arvalid, 0); chk("t6_wvalid", wvalid, 0); chk("t6_awvalid", awvalid, 0);
    chk("t6_busy", busy, 0); chk("t6_dout_rdy", blob_dout_rdy, 1);
    exp_ar_q.delete(); exp_rd_q.delete(); rb_q.delete(); exp_aw_q.delete();
    exp_w_q.delete(); push_q.delete();
    b_pend = 0; rbeat = 0; ar_block = 0; w_block = 0; r_stall = 0;
    @(negedge clk); rst = 1'b0;
    exp_read(0, host_src_addr, 20);
    ar0 = ar_cnt; start_job(0, 20);
    wait_rd_done("t6_clean_rd_done", 500);
    chk("t6_clean_ar", ar_cnt - ar0, 2); chk("t6_clean_rd_left", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
